// File: rtl/set_assoc_cache_if.sv
// Requester, flush and line-memory handshake bundle for set_assoc_cache.
interface set_assoc_cache_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_rd;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_hit;
  logic                  flush_req;
  logic                  flush_done;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic                  mem_rsp_valid;
  logic [LINE_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_is_rd, req_addr, req_wdata, flush_req,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_hit, flush_done,
           mem_req_valid, mem_req_we, mem_req_addr, mem_wdata
  );

  modport master (
    output req_valid, req_is_rd, req_addr, req_wdata, flush_req,
           mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_hit, flush_done,
           mem_req_valid, mem_req_we, mem_req_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate byte cache with age-counter LRU and flush.
// Defining CACHE_STATS_EN adds saturating hit_cnt/miss_cnt statistics ports.
//
// state        | meaning
// IDLE         | ready for a request or a flush
// LOOKUP       | tag compare; hit update or victim selection
// WB           | write back the dirty victim line
// REFILL_REQ   | request the missing line from memory
// REFILL_WAIT  | wait for refill data and install the line
// RESP         | one-cycle response, accessed way becomes MRU
// FLUSH_SCAN   | visit next line, invalidate clean ones, finish after last
// FLUSH_WB     | write back the dirty line found by the scan
module set_assoc_cache #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int NUM_SETS   = 4,
  parameter int NUM_WAYS   = 2
) (
  input logic               clk,
  input logic               rst_n,
  set_assoc_cache_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  localparam int OFF_W  = $clog2(LINE_WIDTH / DATA_WIDTH);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int SCAN_W = IDX_W + WAY_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_REFILL_REQ, S_REFILL_WAIT, S_RESP, S_FLUSH_SCAN, S_FLUSH_WB
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  is_rd_q, is_rd_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic                  hit_q, hit_d;
  logic [SCAN_W-1:0]     scan_q, scan_d;

  logic                  valid_q [NUM_SETS][NUM_WAYS];
  logic                  valid_d [NUM_SETS][NUM_WAYS];
  logic                  dirty_q [NUM_SETS][NUM_WAYS];
  logic                  dirty_d [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]      age_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]      age_d   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      tag_d   [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0] data_d  [NUM_SETS][NUM_WAYS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  assign {req_tag, req_idx, req_off} = addr_q;

  logic [IDX_W-1:0] scan_idx;
  logic [WAY_W-1:0] scan_way;
  logic             scan_end;
  logic             scan_dirty;
  assign scan_idx   = scan_q[WAY_W +: IDX_W];
  assign scan_way   = scan_q[WAY_W-1:0];
  assign scan_end   = scan_q[SCAN_W-1];
  assign scan_dirty = valid_q[scan_idx][scan_way] && dirty_q[scan_idx][scan_way];

  function automatic logic [LINE_WIDTH-1:0] merge_byte(input logic [LINE_WIDTH-1:0] line,
                                                      input logic [OFF_W-1:0]      off,
                                                      input logic [DATA_WIDTH-1:0] b);
    logic [LINE_WIDTH-1:0] r;
    r = line;
    r[off*DATA_WIDTH +: DATA_WIDTH] = b;
    return r;
  endfunction

  // Descending scan so the lowest-index invalid way wins; ages form a permutation, so max age is all-ones.
  logic             hit_any, inv_any;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim_way;
  logic             victim_dirty;
  always_comb begin
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[req_idx][w] == '1) lru_way = WAY_W'(w);
    end
    victim_way   = inv_any ? inv_way : lru_way;
    victim_dirty = valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:        if (bus.flush_req)          state_d = S_FLUSH_SCAN;
                     else if (bus.req_valid)     state_d = S_LOOKUP;
      S_LOOKUP:      if (hit_any)                state_d = S_RESP;
                     else if (victim_dirty)      state_d = S_WB;
                     else                        state_d = S_REFILL_REQ;
      S_WB:          if (bus.mem_req_ready)      state_d = S_REFILL_REQ;
      S_REFILL_REQ:  if (bus.mem_req_ready)      state_d = S_REFILL_WAIT;
      S_REFILL_WAIT: if (bus.mem_rsp_valid)      state_d = S_RESP;
      S_RESP:                                    state_d = S_IDLE;
      S_FLUSH_SCAN:  if (scan_end)               state_d = S_IDLE;
                     else if (scan_dirty)        state_d = S_FLUSH_WB;
      S_FLUSH_WB:    if (bus.mem_req_ready)      state_d = S_FLUSH_SCAN;
      default:                                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = (state_q == S_IDLE);
    bus.rsp_valid     = (state_q == S_RESP);
    bus.rsp_rdata     = (state_q == S_RESP && is_rd_q) ? rdata_q : '0;
    bus.rsp_hit       = (state_q == S_RESP) && hit_q;
    bus.flush_done    = (state_q == S_FLUSH_SCAN) && scan_end;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_wdata     = '0;
    unique case (state_q)
      S_WB: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = {tag_q[req_idx][way_q], req_idx, {OFF_W{1'b0}}};
        bus.mem_wdata     = data_q[req_idx][way_q];
      end
      S_REFILL_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
      end
      S_FLUSH_WB: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = {tag_q[scan_idx][scan_way], scan_idx, {OFF_W{1'b0}}};
        bus.mem_wdata     = data_q[scan_idx][scan_way];
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    is_rd_d = is_rd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    way_d   = way_q;
    hit_d   = hit_q;
    scan_d  = scan_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    age_d   = age_q;
    tag_d   = tag_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.flush_req) begin
          scan_d = '0;
        end else if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          is_rd_d = bus.req_is_rd;
          wdata_d = bus.req_wdata;
        end
      end
      S_LOOKUP: begin
        hit_d = hit_any;
        if (hit_any) begin
          way_d   = hit_way;
          rdata_d = data_q[req_idx][hit_way][req_off*DATA_WIDTH +: DATA_WIDTH];
          if (!is_rd_q) begin
            data_d[req_idx][hit_way]  = merge_byte(data_q[req_idx][hit_way], req_off, wdata_q);
            dirty_d[req_idx][hit_way] = 1'b1;
          end
        end else begin
          way_d = victim_way;
        end
      end
      S_REFILL_WAIT: begin
        if (bus.mem_rsp_valid) begin
          valid_d[req_idx][way_q] = 1'b1;
          tag_d[req_idx][way_q]   = req_tag;
          dirty_d[req_idx][way_q] = !is_rd_q;
          data_d[req_idx][way_q]  = is_rd_q ? bus.mem_rdata
                                            : merge_byte(bus.mem_rdata, req_off, wdata_q);
          rdata_d = bus.mem_rdata[req_off*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      S_RESP: begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == way_q)
            age_d[req_idx][w] = '0;
          else if (age_q[req_idx][w] < age_q[req_idx][way_q])
            age_d[req_idx][w] = age_q[req_idx][w] + WAY_W'(1);
        end
      end
      S_FLUSH_SCAN: begin
        if (!scan_end && !scan_dirty) begin
          valid_d[scan_idx][scan_way] = 1'b0;
          dirty_d[scan_idx][scan_way] = 1'b0;
          scan_d = scan_q + SCAN_W'(1);
        end
      end
      S_FLUSH_WB: begin
        if (bus.mem_req_ready) begin
          valid_d[scan_idx][scan_way] = 1'b0;
          dirty_d[scan_idx][scan_way] = 1'b0;
          scan_d = scan_q + SCAN_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      is_rd_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      scan_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      addr_q  <= addr_d;
      is_rd_q <= is_rd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      scan_q  <= scan_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      age_q   <= age_d;
    end
  end

  // Tags and line data are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_FLUSH_SCAN && scan_end) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (state_q == S_RESP) begin
      if (hit_q && hit_cnt_q != 16'hFFFF)   hit_cnt_d  = hit_cnt_q + 16'd1;
      if (!hit_q && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache: directed scenarios plus random traffic
// checked against a per-set recency-list model and a line-granular memory model.
module tb_set_assoc_cache;
  localparam int AW = 16, DW = 8, LW = 32, NS = 4, NW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  set_assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW)) cif();
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  set_assoc_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW),
                    .NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cif)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  typedef struct packed {
    logic [15:0] la;
    logic [31:0] line;
    logic        dirty;
  } ent_t;

  ent_t        cm [NS][$];          // front = most recently used
  logic [31:0] mem_model [logic [15:0]];
  logic [15:0] fl_la [$];
  int total = 0, bad = 0;
  int m_hits = 0, m_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [15:0] la);
    if (mem_model.exists(la)) return mem_model[la];
    return {la, ~la} ^ 32'h3C5A_96E1;
  endfunction

  task automatic model_access(input bit is_rd, input logic [15:0] addr, input logic [7:0] wd,
                              output bit hit, output logic [7:0] rd, output bit wb,
                              output logic [15:0] wb_la, output logic [31:0] wb_line);
    int s, off, found;
    ent_t e;
    logic [15:0] la;
    la = addr & 16'hFFFC;
    s = int'(addr[3:2]);
    off = int'(addr[1:0]);
    found = -1;
    for (int i = 0; i < cm[s].size(); i++) if (cm[s][i].la == la) found = i;
    wb = 1'b0; wb_la = '0; wb_line = '0; rd = '0;
    if (found >= 0) begin
      hit = 1'b1;
      e = cm[s][found];
      cm[s].delete(found);
      m_hits++;
    end else begin
      hit = 1'b0;
      m_miss++;
      if (cm[s].size() == NW) begin
        e = cm[s].pop_back();
        if (e.dirty) begin
          wb = 1'b1; wb_la = e.la; wb_line = e.line;
          mem_model[e.la] = e.line;
        end
      end
      e.la = la; e.line = mem_rd(la); e.dirty = 1'b0;
    end
    if (is_rd) rd = e.line[off*8 +: 8];
    else begin
      e.line[off*8 +: 8] = wd;
      e.dirty = 1'b1;
    end
    cm[s].push_front(e);
  endtask

  // Entered and left at a falling edge with the cache idle.
  task automatic do_access(input bit is_rd, input logic [15:0] addr, input logic [7:0] wd,
                           input int wb_delay, output bit got_hit, output logic [7:0] got_rd,
                           output logic [15:0] got_wb_la, output logic [31:0] got_wb_line,
                           output int lat);
    bit e_hit, e_wb, got, rf_pend, unstable;
    logic [7:0] e_rd;
    logic [15:0] e_wb_la, rf_la;
    logic [31:0] e_wb_line;
    int n_wb, n_rf, stall, e_lat;
    model_access(is_rd, addr, wd, e_hit, e_rd, e_wb, e_wb_la, e_wb_line);
    e_lat = e_hit ? 2 : (e_wb ? 5 + wb_delay : 4);
    got = 0; rf_pend = 0; unstable = 0; n_wb = 0; n_rf = 0; stall = 0; lat = 0;
    got_hit = 0; got_rd = '0; got_wb_la = '0; got_wb_line = '0; rf_la = '0;
    chk("req_ready_idle", cif.req_ready, 1);
    cif.req_valid = 1'b1; cif.req_is_rd = is_rd; cif.req_addr = addr; cif.req_wdata = wd;
    @(posedge clk); #1;
    cif.req_valid = 1'b0;
    while (!got && lat < 64) begin
      @(negedge clk); lat++;
      cif.mem_rsp_valid = 1'b0;
      cif.mem_req_ready = 1'b0;
      if (cif.rsp_valid) begin
        got = 1; got_hit = cif.rsp_hit; got_rd = cif.rsp_rdata;
      end else begin
        if (rf_pend) begin
          cif.mem_rsp_valid = 1'b1;
          cif.mem_rdata = mem_rd(rf_la);
          rf_pend = 0;
        end
        if (cif.mem_req_valid) begin
          if (cif.mem_req_we) begin
            if (stall == 0) begin
              got_wb_la = cif.mem_req_addr; got_wb_line = cif.mem_wdata;
            end else if (cif.mem_req_addr !== got_wb_la || cif.mem_wdata !== got_wb_line) begin
              unstable = 1;
            end
            if (stall < wb_delay) stall++;
            else begin cif.mem_req_ready = 1'b1; n_wb++; stall = 0; end
          end else begin
            cif.mem_req_ready = 1'b1; n_rf++; rf_la = cif.mem_req_addr; rf_pend = 1;
          end
        end
      end
    end
    cif.mem_req_ready = 1'b0;
    cif.mem_rsp_valid = 1'b0;
    chk("rsp_timeout", got, 1);
    chk("latency", lat, e_lat);
    chk("rsp_hit", got_hit, e_hit);
    chk("rsp_rdata", got_rd, e_rd);
    chk("wb_count", n_wb, e_wb);
    if (e_wb && n_wb == 1) begin
      chk("wb_addr", got_wb_la, e_wb_la);
      chk("wb_data", got_wb_line, e_wb_line);
      chk("wb_stable", unstable, 0);
    end
    chk("refill_count", n_rf, e_hit ? 0 : 1);
    if (!e_hit && n_rf == 1) chk("refill_addr", rf_la, addr & 16'hFFFC);
    @(negedge clk);
    chk("rsp_one_cycle", cif.rsp_valid, 0);
  endtask

  task automatic do_flush();
    ent_t exp_q [$];
    logic [31:0] ln [$];
    bit done, rdy_seen, rd_seen, order_bad, match_bad;
    int cyc, prev_set, found;
    done = 0; rdy_seen = 0; rd_seen = 0; order_bad = 0; match_bad = 0; cyc = 0; prev_set = 0;
    fl_la.delete();
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < cm[s].size(); i++) begin
        if (cm[s][i].dirty) begin
          exp_q.push_back(cm[s][i]);
          mem_model[cm[s][i].la] = cm[s][i].line;
        end
      end
      cm[s].delete();
    end
    m_hits = 0; m_miss = 0;
    cif.flush_req = 1'b1;
    @(posedge clk); #1;
    cif.flush_req = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk); cyc++;
      cif.mem_req_ready = 1'b0;
      if (cif.flush_done) done = 1;
      else begin
        if (cif.req_ready) rdy_seen = 1;
        if (cif.mem_req_valid) begin
          if (!cif.mem_req_we) rd_seen = 1;
          cif.mem_req_ready = 1'b1;
          fl_la.push_back(cif.mem_req_addr);
          ln.push_back(cif.mem_wdata);
        end
      end
    end
    cif.mem_req_ready = 1'b0;
    chk("flush_done_seen", done, 1);
    chk("flush_wb_count", fl_la.size(), exp_q.size());
    chk("flush_ready_low", rdy_seen, 0);
    chk("flush_no_refill", rd_seen, 0);
    for (int i = 0; i < fl_la.size(); i++) begin
      if (int'(fl_la[i][3:2]) < prev_set) order_bad = 1;
      prev_set = int'(fl_la[i][3:2]);
      found = -1;
      for (int j = 0; j < exp_q.size(); j++)
        if (exp_q[j].la == fl_la[i] && exp_q[j].line == ln[i]) found = j;
      if (found >= 0) exp_q.delete(found);
      else match_bad = 1;
    end
    chk("flush_set_order", order_bad, 0);
    chk("flush_wb_match", match_bad, 0);
    @(negedge clk);
    chk("flush_done_pulse", cif.flush_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h; logic [7:0] rd; logic [15:0] wla; logic [31:0] wln; int lat, lat_dirty, cyc;
    cif.req_valid = 0; cif.req_is_rd = 0; cif.req_addr = '0; cif.req_wdata = '0;
    cif.flush_req = 0; cif.mem_req_ready = 0; cif.mem_rsp_valid = 0; cif.mem_rdata = '0;
    mem_model[16'h0010] = 32'hDDCCBBAA;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", cif.req_ready, 1);
    chk("reset_mem_valid", cif.mem_req_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rsp_valid", cif.rsp_valid, 0);
    chk("idle_flush_done", cif.flush_done, 0);

    do_access(1, 16'h0010, 8'h00, 0, h, rd, wla, wln, lat);
    chk("dir_miss_rdata", rd, 8'hAA);
    chk("dir_miss_lat", lat, 4);
    do_access(1, 16'h0013, 8'h00, 0, h, rd, wla, wln, lat);
    chk("dir_hit_rdata", rd, 8'hDD);
    chk("dir_hit_lat", lat, 2);
    do_access(0, 16'h0011, 8'h55, 0, h, rd, wla, wln, lat);
    do_access(1, 16'h0050, 8'h00, 0, h, rd, wla, wln, lat);
    do_access(1, 16'h0090, 8'h00, 0, h, rd, wla, wln, lat);
    chk("dir_evict_addr", wla, 16'h0010);
    chk("dir_evict_data", wln, 32'hDDCC55AA);
    lat_dirty = lat;
    do_access(0, 16'h0051, 8'h66, 0, h, rd, wla, wln, lat);
    do_access(1, 16'h0090, 8'h00, 0, h, rd, wla, wln, lat);
    do_access(1, 16'h00D0, 8'h00, 5, h, rd, wla, wln, lat);
    chk("dir_stall_addr", wla, 16'h0050);
    chk("dir_stall_delta", lat - lat_dirty, 5);

    do_access(0, 16'h0004, 8'hA1, 0, h, rd, wla, wln, lat);
    do_access(0, 16'h000C, 8'hC3, 0, h, rd, wla, wln, lat);
    do_flush();
    chk("dir_flush_n", fl_la.size(), 2);
    if (fl_la.size() == 2) begin
      chk("dir_flush_first", fl_la[0], 16'h0004);
      chk("dir_flush_second", fl_la[1], 16'h000C);
    end
    do_access(1, 16'h0004, 8'h00, 0, h, rd, wla, wln, lat);
    chk("dir_after_flush_miss", h, 0);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 39) == 0) do_flush();
      else begin
        logic [15:0] a;
        a = 16'(($urandom_range(0, 5) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
        do_access(1'($urandom_range(0, 1)), a, 8'($urandom), $urandom_range(0, 3),
                  h, rd, wla, wln, lat);
      end
    end
`ifdef CACHE_STATS_EN
    chk("rand_hit_cnt", hit_cnt, 16'(m_hits));
    chk("rand_miss_cnt", miss_cnt, 16'(m_miss));
`endif

    do_flush();
    cif.req_valid = 1'b1; cif.req_is_rd = 1'b1; cif.req_addr = 16'h0200;
    @(posedge clk); #1;
    cif.req_valid = 1'b0;
    cyc = 0;
    while (!cif.mem_req_valid && cyc < 10) begin @(negedge clk); cyc++; end
    chk("rst_refill_req", cif.mem_req_valid, 1);
    cif.mem_req_ready = 1'b1;
    @(negedge clk);
    cif.mem_req_ready = 1'b0;
    chk("rst_wait_busy", cif.req_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_ready", cif.req_ready, 1);
    chk("rst_async_mem_valid", cif.mem_req_valid, 0);
    chk("rst_async_mem_addr", cif.mem_req_addr, 0);
    chk("rst_async_rsp_valid", cif.rsp_valid, 0);
`ifdef CACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 0);
`endif
    for (int s = 0; s < NS; s++) cm[s].delete();
    m_hits = 0; m_miss = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1, 16'h0200, 8'h00, 0, h, rd, wla, wln, lat);
    chk("post_rst_miss", h, 0);
    do_access(1, 16'h0201, 8'h00, 0, h, rd, wla, wln, lat);
    do_access(0, 16'h0202, 8'h9A, 0, h, rd, wla, wln, lat);
    do_access(1, 16'h0203, 8'h00, 0, h, rd, wla, wln, lat);
    do_access(1, 16'h0300, 8'h00, 0, h, rd, wla, wln, lat);
`ifdef CACHE_STATS_EN
    chk("stats_hit_cnt", hit_cnt, 16'd3);
    chk("stats_miss_cnt", miss_cnt, 16'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
